playseq_motor_param: RTL and testbench
======================================

Name: playseq_motor_param

Overview:
Parametrised, self-sequenced PlaySeq game engine: the next generation of the PlaySeq datapath, with its control FSM built in.
- Holds a loadable sequence memory of one-hot symbols for N buttons.
- Each round, shows the sequence prefix 0..rodada on the LEDs, then checks the player's presses against it.
- Grows the prefix each round until a programmable limit is reached, with per-move timeout.
- Sits between the board I/O (buttons, LEDs) and the top-level/debug displays.

Parameters:
N, 4, number of buttons/LEDs (symbol width)
DEPTH_W, 4, address width; memory holds 2**DEPTH_W symbols
T_LED, 500, clock cycles a symbol is lit in preview, and also the dark gap after it (>=1)
T_JOGADA, 5000, clock cycles allowed per move before timeout (>=1)

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
iniciar  in  1  start/restart game (sampled in OCIOSO, FIM_GANHOU, FIM_PERDEU)
botoes  in  N  button levels, already synchronised
limite  in  DEPTH_W  index of last round; final sequence length = limite+1
carga_we  in  1  memory write enable (honoured only in OCIOSO)
carga_addr  in  DEPTH_W  memory write address
carga_dado  in  N  memory write data
leds  out  N  LED drive
pronto  out  1  game finished (high in FIM_GANHOU/FIM_PERDEU)
ganhou  out  1  win flag
perdeu  out  1  loss flag (wrong symbol or timeout)
timeout  out  1  loss was caused by timeout
db_estado  out  4  FSM state code
db_rodada  out  DEPTH_W  current round index
db_endereco  out  DEPTH_W  current memory address

Behaviour:
- Memory: 2**DEPTH_W x N register array; combinational read at endereco; written on the clock edge when carga_we=1 and state=OCIOSO. Writes are ignored in all other states. Contents are not cleared by reset.
- Edge detect: prev <= |botoes every cycle in every state; prev=0 on reset. press = |botoes & ~prev. A button already held on entry to ESPERA does not count as a press until released and pressed again.
- Reset: state=OCIOSO; rodada=0; endereco=0; timer=0; reg_jogada=0; leds=0; pronto=ganhou=perdeu=timeout=0. Reset mid-game aborts the game; OCIOSO is reached on the same edge.
- State codes: OCIOSO=0, MOSTRA=1, APAGA=2, ESPERA=3, COMPARA=4, FIM_GANHOU=5, FIM_PERDEU=6.
- OCIOSO: leds=0. On iniciar -> MOSTRA; rodada=0, endereco=0, timer=0, all flags cleared.
- MOSTRA:
  - leds=mem[endereco]; timer increments.
  - When timer==T_LED-1 -> APAGA, timer=0.
- APAGA:
  - leds=0 for T_LED cycles.
  - At timer==T_LED-1: if endereco==rodada -> ESPERA with endereco=0, timer=0; else endereco+1 -> MOSTRA, timer=0.
- ESPERA:
  - leds=botoes; timer increments.
  - On press -> reg_jogada<=botoes, -> COMPARA, timer=0.
  - Else if timer==T_JOGADA-1 -> FIM_PERDEU with perdeu=1, timeout=1.
  - Press takes priority over timeout in the same cycle.
- COMPARA (1 cycle, leds=reg_jogada):
  - If reg_jogada != mem[endereco] -> FIM_PERDEU, perdeu=1. Multi-button presses are compared bitwise as-is.
  - Else if endereco != rodada -> endereco+1, -> ESPERA.
  - Else if rodada == limite -> FIM_GANHOU, ganhou=1.
  - Else rodada+1, endereco=0, -> MOSTRA.
  - timer=0 on every exit.
- Response latency: a verdict is visible 2 edges after the press edge (ESPERA->COMPARA->FIM/next).
- FIM_GANHOU/FIM_PERDEU: pronto=1; flags and leds=0 held. iniciar -> MOSTRA, restarting as from OCIOSO (flags cleared, memory kept).
- limite is sampled live; it must be held stable during a game. If limite < rodada at a round end, the game continues until the counter wraps and matches limite. This case is unsupported but must not hang.
- Counters: timer width is clog2(max(T_LED,T_JOGADA)); rodada and endereco wrap modulo 2**DEPTH_W.
- Flags and db_* are registered outputs; leds are combinational from state/memory/botoes.

Test Plan:
- N=4, DEPTH_W=4, T_LED=2, T_JOGADA=8. Load mem[0..2]=1,2,4; limite=2; iniciar → leds show 0001 2 cycles, 0000 2 cycles, then ESPERA, db_estado=3.
- Same setup, correct presses through all rounds (press 1 / 1,2 / 1,2,4, each held 1 cycle then released) → ganhou=1, pronto=1, perdeu=0, db_rodada=2.
- Round 1: second press 4'b1000 instead of 0010 → perdeu=1, timeout=0, state 6 two edges after the press.
- In ESPERA, no press for 8 cycles → perdeu=1, timeout=1; a press on the 8th cycle → COMPARA instead.
- Hold button 0001 across the APAGA→ESPERA entry → no COMPARA until release and re-press. carga_we during MOSTRA → memory unchanged (check on replay).
- Assert reset in ESPERA → next edge db_estado=0, all flags 0. Memory retained: replay after iniciar shows the same sequence.

Source files
------------

// File: rtl/playseq_motor_param.sv
// PlaySeq engine: loadable one-hot symbol memory, LED preview of a growing prefix, checked player input with per-move timeout.
// Verdict two edges after a press; no backpressure, inputs sampled every cycle and presses are edge-detected.
module playseq_motor_param #(
    parameter int N        = 4,
    parameter int DEPTH_W  = 4,
    parameter int T_LED    = 500,
    parameter int T_JOGADA = 5000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [N-1:0]       botoes,
    input  logic [DEPTH_W-1:0] limite,
    input  logic               carga_we,
    input  logic [DEPTH_W-1:0] carga_addr,
    input  logic [N-1:0]       carga_dado,
    output logic [N-1:0]       leds,
    output logic               pronto,
    output logic               ganhou,
    output logic               perdeu,
    output logic               timeout,
    output logic [3:0]         db_estado,
    output logic [DEPTH_W-1:0] db_rodada,
    output logic [DEPTH_W-1:0] db_endereco
);

    localparam int TMAX = (T_LED > T_JOGADA) ? T_LED : T_JOGADA;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] LED_LAST = TW'(T_LED - 1);
    localparam logic [TW-1:0] JOG_LAST = TW'(T_JOGADA - 1);

    localparam logic [2:0] OCIOSO     = 3'd0;
    localparam logic [2:0] MOSTRA     = 3'd1;
    localparam logic [2:0] APAGA      = 3'd2;
    localparam logic [2:0] ESPERA     = 3'd3;
    localparam logic [2:0] COMPARA    = 3'd4;
    localparam logic [2:0] FIM_GANHOU = 3'd5;
    localparam logic [2:0] FIM_PERDEU = 3'd6;

    logic [N-1:0]       mem_q [2**DEPTH_W];
    logic [2:0]         estado_q, estado_d;
    logic [DEPTH_W-1:0] rodada_q, rodada_d;
    logic [DEPTH_W-1:0] endereco_q, endereco_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N-1:0]       jogada_q, jogada_d;
    logic               prev_q;
    logic               pronto_q, pronto_d;
    logic               ganhou_q, ganhou_d;
    logic               perdeu_q, perdeu_d;
    logic               timeout_q, timeout_d;
    logic [N-1:0]       simbolo;
    logic               press;

    assign simbolo = mem_q[endereco_q];
    assign press   = (|botoes) & ~prev_q;

    always_comb begin
        estado_d   = estado_q;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        timer_d    = timer_q;
        jogada_d   = jogada_q;
        pronto_d   = pronto_q;
        ganhou_d   = ganhou_q;
        perdeu_d   = perdeu_q;
        timeout_d  = timeout_q;
        case (estado_q)
            OCIOSO, FIM_GANHOU, FIM_PERDEU: begin
                if (iniciar) begin
                    estado_d   = MOSTRA;
                    rodada_d   = '0;
                    endereco_d = '0;
                    timer_d    = '0;
                    pronto_d   = 1'b0;
                    ganhou_d   = 1'b0;
                    perdeu_d   = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            MOSTRA: begin
                if (timer_q == LED_LAST) begin
                    estado_d = APAGA;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            APAGA: begin
                if (timer_q == LED_LAST) begin
                    timer_d = '0;
                    if (endereco_q == rodada_q) begin
                        estado_d   = ESPERA;
                        endereco_d = '0;
                    end else begin
                        estado_d   = MOSTRA;
                        endereco_d = endereco_q + DEPTH_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ESPERA: begin
                // A press on the final cycle still wins over the timeout.
                if (press) begin
                    jogada_d = botoes;
                    estado_d = COMPARA;
                    timer_d  = '0;
                end else if (timer_q == JOG_LAST) begin
                    estado_d  = FIM_PERDEU;
                    timer_d   = '0;
                    pronto_d  = 1'b1;
                    perdeu_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COMPARA: begin
                timer_d = '0;
                if (jogada_q != simbolo) begin
                    estado_d = FIM_PERDEU;
                    pronto_d = 1'b1;
                    perdeu_d = 1'b1;
                end else if (endereco_q != rodada_q) begin
                    estado_d   = ESPERA;
                    endereco_d = endereco_q + DEPTH_W'(1);
                end else if (rodada_q == limite) begin
                    estado_d = FIM_GANHOU;
                    pronto_d = 1'b1;
                    ganhou_d = 1'b1;
                end else begin
                    estado_d   = MOSTRA;
                    rodada_d   = rodada_q + DEPTH_W'(1);
                    endereco_d = '0;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            rodada_q   <= '0;
            endereco_q <= '0;
            timer_q    <= '0;
            jogada_q   <= '0;
            prev_q     <= 1'b0;
            pronto_q   <= 1'b0;
            ganhou_q   <= 1'b0;
            perdeu_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            rodada_q   <= rodada_d;
            endereco_q <= endereco_d;
            timer_q    <= timer_d;
            jogada_q   <= jogada_d;
            prev_q     <= |botoes;
            pronto_q   <= pronto_d;
            ganhou_q   <= ganhou_d;
            perdeu_q   <= perdeu_d;
            timeout_q  <= timeout_d;
        end
    end

    // Sequence memory survives reset so a game can be replayed.
    always_ff @(posedge clock) begin
        if (carga_we && estado_q == OCIOSO)
            mem_q[carga_addr] <= carga_dado;
    end

    always_comb begin
        case (estado_q)
            MOSTRA:  leds = simbolo;
            ESPERA:  leds = botoes;
            COMPARA: leds = jogada_q;
            default: leds = '0;
        endcase
    end

    assign pronto      = pronto_q;
    assign ganhou      = ganhou_q;
    assign perdeu      = perdeu_q;
    assign timeout     = timeout_q;
    assign db_estado   = {1'b0, estado_q};
    assign db_rodada   = rodada_q;
    assign db_endereco = endereco_q;

endmodule

// File: tb/tb_playseq_motor_param.sv
// Directed bench for playseq_motor_param: preview LEDs checked from a queue, verdicts checked against a reference memory.
module tb_playseq_motor_param;

    localparam int N  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset, iniciar, carga_we;
    logic [N-1:0]  botoes, carga_dado;
    logic [DW-1:0] limite, carga_addr;
    logic [N-1:0]  leds;
    logic          pronto, ganhou, perdeu, timeout;
    logic [3:0]    db_estado;
    logic [DW-1:0] db_rodada, db_endereco;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] model_mem [3];
    logic [N-1:0] exp_q [$];

    playseq_motor_param #(.N(N), .DEPTH_W(DW), .T_LED(2), .T_JOGADA(8)) dut (
        .clock(clk), .reset(reset), .iniciar(iniciar), .botoes(botoes), .limite(limite),
        .carga_we(carga_we), .carga_addr(carga_addr), .carga_dado(carga_dado),
        .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .db_estado(db_estado), .db_rodada(db_rodada), .db_endereco(db_endereco)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_flags(input string tag);
        chk({tag, "_estado"},   32'(db_estado), 32'd0);
        chk({tag, "_flags"},    32'({pronto, ganhou, perdeu, timeout}), 32'd0);
        chk({tag, "_leds"},     32'(leds), 32'd0);
        chk({tag, "_rodada"},   32'(db_rodada), 32'd0);
        chk({tag, "_endereco"}, 32'(db_endereco), 32'd0);
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("start_state", 32'(db_estado), 32'd1);
    endtask

    // Each symbol of the prefix is lit 2 cycles then dark 2 cycles.
    task automatic show_check(input int r);
        logic [N-1:0] e;
        for (int a = 0; a <= r; a++) begin
            exp_q.push_back(model_mem[a]);
            exp_q.push_back(model_mem[a]);
            exp_q.push_back('0);
            exp_q.push_back('0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("preview_leds", 32'(leds), 32'(e));
            tick();
        end
        chk("espera_state", 32'(db_estado), 32'd3);
    endtask

    task automatic press(input logic [N-1:0] sym, input int exp_state);
        botoes = sym;
        tick();
        chk("compara_state", 32'(db_estado), 32'd4);
        chk("compara_leds", 32'(leds), 32'(sym));
        botoes = '0;
        tick();
        chk("verdict_state", 32'(db_estado), 32'(exp_state));
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; carga_we = 1'b0; botoes = '0;
        limite = '0; carga_addr = '0; carga_dado = '0;
        tick();
        tick();
        reset = 1'b0;
        check_idle_flags("reset");

        model_mem[0] = 4'b0001; model_mem[1] = 4'b0010; model_mem[2] = 4'b0100;
        for (int a = 0; a < 3; a++) begin
            carga_we = 1'b1; carga_addr = DW'(a); carga_dado = model_mem[a];
            tick();
        end
        carga_we = 1'b0;
        limite = 4'd2;

        // Full winning game.
        start_game();
        for (int r = 0; r <= 2; r++) begin
            show_check(r);
            for (int a = 0; a <= r; a++)
                press(model_mem[a], (a < r) ? 3 : ((r < 2) ? 1 : 5));
        end
        chk("win_ganhou", 32'(ganhou), 32'd1);
        chk("win_pronto", 32'(pronto), 32'd1);
        chk("win_perdeu", 32'(perdeu), 32'd0);
        chk("win_rodada", 32'(db_rodada), 32'd2);
        chk("win_leds", 32'(leds), 32'd0);

        // Wrong symbol in round 1.
        start_game();
        chk("restart_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'd0);
        show_check(0);
        press(model_mem[0], 1);
        show_check(1);
        press(model_mem[0], 3);
        press(4'b1000, 6);
        chk("wrong_perdeu", 32'(perdeu), 32'd1);
        chk("wrong_timeout", 32'(timeout), 32'd0);
        chk("wrong_pronto", 32'(pronto), 32'd1);
        chk("wrong_ganhou", 32'(ganhou), 32'd0);

        // No press for 8 cycles.
        start_game();
        show_check(0);
        repeat (7) tick();
        chk("pre_timeout_state", 32'(db_estado), 32'd3);
        tick();
        chk("timeout_state", 32'(db_estado), 32'd6);
        chk("timeout_perdeu", 32'(perdeu), 32'd1);
        chk("timeout_flag", 32'(timeout), 32'd1);

        // Press on the last allowed cycle beats the timeout.
        start_game();
        show_check(0);
        repeat (7) tick();
        press(model_mem[0], 1);
        chk("late_press_perdeu", 32'(perdeu), 32'd0);

        // Button held across ESPERA entry; loads during preview must be ignored.
        botoes = 4'b0001;
        carga_we = 1'b1; carga_addr = '0; carga_dado = 4'b1000;
        show_check(1);
        carga_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_state", 32'(db_estado), 32'd3);
            chk("held_leds", 32'(leds), 32'd1);
        end
        botoes = '0;
        tick();
        chk("released_state", 32'(db_estado), 32'd3);
        press(model_mem[0], 3);
        chk("espera_endereco", 32'(db_endereco), 32'd1);

        // Reset while waiting for a move.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_flags("midgame_reset");

        // Replay shows the original, unmodified sequence.
        start_game();
        show_check(0);
        press(model_mem[0], 1);
        show_check(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
